// File: rtl/inst_fetch_unit.sv
// ============================================================================
// inst_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage feeding the control unit / decode.
//
// Owns the program counter and talks to a variable-latency instruction memory
// with at most one request outstanding. Each returned word is presented to
// decode, together with the PC it was fetched from, through a valid/ready
// handshake. Execute can redirect the PC (taken JAL/JALR/branch) and the
// control unit can halt the stage (ECALL). Any fetch already in flight when a
// redirect arrives is squashed when its response comes back.
//
// Parameters
//   XLEN               datapath / address width
//   RESET_PC           PC value loaded while reset is asserted
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_reset            asynchronous active-high reset
//   o_imem_req         fetch request valid (only while in FETCH)
//   o_imem_addr        fetch address, always the current PC
//   i_imem_ready       memory accepts the request this cycle
//   i_imem_rvalid      memory returns instruction data this cycle
//   i_imem_rdata       returned instruction word
//   o_inst_valid       o_inst / o_inst_pc valid to decode (HOLD)
//   o_inst             instruction word held for decode
//   o_inst_pc          PC of o_inst
//   i_inst_ready       decode consumes the held instruction this cycle
//   i_redirect         execute resolved a taken control transfer
//   i_redirect_target  new PC; the two low bits are cleared on load
//   i_halt             ECALL halt request from the control unit
//   o_is_halted        sticky halted indication, cleared only by reset
// ============================================================================
module inst_fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_inst_valid,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_halt,
    output logic            o_is_halted
);

    // ------------------------------------------------------------------------
    // Fetch states:
    //   IDLE   - first cycle after reset release
    //   FETCH  - request driven with the current PC, waiting for acceptance
    //   WAIT   - request accepted, waiting for the response
    //   HOLD   - instruction held for decode until consumed
    //   HALTED - terminal until reset
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_kill;
    logic [31:0]       r_inst;
    logic [XLEN-1:0]   r_inst_pc;

    state_t            w_state_next;
    logic [XLEN-1:0]   w_pc_next;
    logic [XLEN-1:0]   w_fetch_pc_next;
    logic              w_kill_next;
    logic [31:0]       w_inst_next;
    logic [XLEN-1:0]   w_inst_pc_next;

    logic [XLEN-1:0]   w_redirect_pc;
    logic [XLEN-1:0]   w_pc_plus4;

    // Redirect targets are forced word-aligned; masking keeps every target
    // bit in use rather than slicing off the low two.
    assign w_redirect_pc = i_redirect_target & ~(XLEN'(3));

    // Sequential PC wraps naturally modulo 2^XLEN.
    assign w_pc_plus4    = r_pc + XLEN'(4);

    // ------------------------------------------------------------------------
    // Outputs are pure decodes of registered state, so no input ever reaches
    // an output combinationally.
    // ------------------------------------------------------------------------
    assign o_imem_req   = (r_state == S_FETCH);
    assign o_imem_addr  = r_pc;
    assign o_inst_valid = (r_state == S_HOLD);
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_is_halted  = (r_state == S_HALTED);

    // ------------------------------------------------------------------------
    // State and datapath registers. Reset is asynchronous so the outputs
    // drop to their reset values in the same cycle reset is raised.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_fetch_pc <= '0;
            r_kill     <= 1'b0;
            r_inst     <= '0;
            r_inst_pc  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_kill     <= w_kill_next;
            r_inst     <= w_inst_next;
            r_inst_pc  <= w_inst_pc_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic. Halt wins over redirect, which wins over
    // the normal fetch progression. A redirect that lands while a request is
    // outstanding (or being accepted) sets the kill flag so the stale
    // response is thrown away instead of reaching decode.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_fetch_pc_next = r_fetch_pc;
        w_kill_next     = r_kill;
        w_inst_next     = r_inst;
        w_inst_pc_next  = r_inst_pc;

        if (r_state == S_HALTED) begin
            w_state_next = S_HALTED;
            w_kill_next  = 1'b0;
        end else if (i_halt) begin
            w_state_next = S_HALTED;
            w_kill_next  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_FETCH;
                    if (i_redirect) begin
                        w_pc_next = w_redirect_pc;
                    end
                end

                S_FETCH: begin
                    if (i_redirect) begin
                        w_pc_next = w_redirect_pc;
                    end
                    // The accepted request carried the old PC, so it must be
                    // squashed if a redirect arrives in the same cycle.
                    if (i_imem_ready) begin
                        w_state_next    = S_WAIT;
                        w_fetch_pc_next = r_pc;
                        w_kill_next     = i_redirect;
                    end
                end

                S_WAIT: begin
                    if (i_redirect) begin
                        w_pc_next = w_redirect_pc;
                        if (i_imem_rvalid) begin
                            w_state_next = S_FETCH;
                            w_kill_next  = 1'b0;
                        end else begin
                            w_kill_next  = 1'b1;
                        end
                    end else if (i_imem_rvalid) begin
                        if (r_kill) begin
                            w_state_next = S_FETCH;
                            w_kill_next  = 1'b0;
                        end else begin
                            w_state_next   = S_HOLD;
                            w_inst_next    = i_imem_rdata;
                            w_inst_pc_next = r_fetch_pc;
                        end
                    end
                end

                S_HOLD: begin
                    // A redirect drops the held instruction even if decode
                    // takes it this cycle; the PC does not step past it.
                    if (i_redirect) begin
                        w_state_next = S_FETCH;
                        w_pc_next    = w_redirect_pc;
                    end else if (i_inst_ready) begin
                        w_state_next = S_FETCH;
                        w_pc_next    = w_pc_plus4;
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                    w_kill_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage sitting directly upstream of the control unit. Owns the program counter, issues one-outstanding requests to a variable-latency instruction memory, and presents each fetched instruction and its PC to decode through a valid/ready handshake. Redirects from execute (taken JAL/JALR/branch) and the ECALL halt from control are accepted here; in-flight fetches are squashed.

## Interface
- XLEN, 32, datapath and address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (current PC)
- imem_ready  in  1  memory accepts request this cycle (qualified by imem_req)
- imem_rvalid  in  1  instruction data returned
- imem_rdata  in  32  returned instruction word
- inst_valid  out  1  inst/inst_pc valid to decode
- inst  out  32  instruction to decode (feeds part_of_inst = inst[6:0])
- inst_pc  out  XLEN  PC of inst
- inst_ready  in  1  decode consumes inst this cycle
- redirect  in  1  execute resolved a taken JAL/JALR/branch
- redirect_target  in  XLEN  new PC; bits [1:0] forced to 0 on load
- halt  in  1  ECALL halt from control unit
- is_halted  out  1  sticky halted indication

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALTED. Plus a 1-bit kill flag (valid only in WAIT).
- Reset values: state IDLE, pc RESET_PC, kill 0, imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, is_halted 0.
- imem_req = (state==FETCH); imem_addr = pc; inst_valid = (state==HOLD); is_halted = (state==HALTED).
- IDLE -> FETCH unconditionally (first cycle after reset release).
- FETCH: imem_ready=1 -> WAIT, fetch_pc <= pc. Else stay.
- WAIT: imem_rvalid=1 and kill=0 -> HOLD, inst <= imem_rdata, inst_pc <= fetch_pc. imem_rvalid=1 and kill=1 -> FETCH, kill <= 0, response discarded.
- HOLD: inst_ready=1 -> FETCH, pc <= pc + 4. inst/inst_pc stable while stalled.
- HALTED: terminal until reset; imem_req 0, inst_valid 0, all inputs ignored including imem_rvalid.
- Priority each cycle: halt > redirect > normal transition.
- halt=1 in any state -> HALTED next cycle; an outstanding request's response is ignored.
- redirect=1: pc <= {redirect_target[XLEN-1:2],2'b00} regardless of state, and:
  - FETCH: stays FETCH; if imem_ready=1 same cycle, go WAIT with kill <= 1 (request carried old pc).
  - WAIT: stay WAIT, kill <= 1; if imem_rvalid=1 same cycle, drop it and go FETCH, kill <= 0.
  - HOLD: go FETCH; held inst dropped even if inst_ready=1 same cycle (no pc+4).
  - IDLE: go FETCH with new pc.
- PC arithmetic modulo 2^XLEN: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- imem_rvalid outside WAIT is a protocol error; ignored.
- Only one request outstanding; imem_req never asserted while in WAIT.

## Timing
- All outputs are state-decoded registers; no combinational path from any input to any output.
- Best-case throughput: req accepted cycle n, rvalid n+1, inst_valid n+2, consumed n+2, next req n+3 (one instruction per 3 cycles).
- Memory latency: response no earlier than the cycle after acceptance; unbounded upper limit.
- Redirect/halt take effect on the edge of the cycle they are sampled; observable next cycle.
- Reset mid-operation: all outputs return to reset values asynchronously; in-flight response after release is discarded (state IDLE/FETCH ignores rvalid).

## Test plan
- Reset release, memory returning inst[i]=0x00000013 with 1-cycle latency, inst_ready held 1 -> inst_pc sequence 0x0,0x4,0x8, inst_valid high every 3rd cycle, first at cycle 3 after release.
- Decode stall: inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, imem_req 0, pc advances by exactly 4 after release.
- Redirect in WAIT to 0x100 with 4-cycle memory latency -> stale response dropped, next imem_addr=0x100, next inst_pc=0x100.
- Redirect with target 0x203 coincident with imem_ready in FETCH -> response killed, subsequent imem_addr=0x200.
- halt asserted in WAIT, rvalid arrives later -> is_halted=1 next cycle, inst_valid stays 0, imem_req stays 0 until reset.
- RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=0x0; async reset pulse mid-WAIT -> outputs at reset values in same cycle.
